// File: rtl/dram_bridge_pkg.sv
// Shared types for the data-memory bridge: FSM state encoding and the
// captured request record driven onto the memory bus.
package dram_bridge_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_MASK_W = BUS_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    typedef struct packed {
        logic                  wen;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_MASK_W-1:0] wmask;
    } req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; hit flags the enabled cycle
// whose increment reaches the limit.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         hit
);

    logic [W-1:0] count_q;
    logic [W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
    assign hit       = en && (count_inc >= {1'b0, limit});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (en && (count_q < limit)) begin
            count_q <= count_inc[W-1:0];
        end
    end

endmodule

// File: rtl/dram_bridge.sv
// Bridges the core's zero-latency data-RAM port onto a valid/ready request
// channel plus response strobe, stalling the core until the response lands.
module dram_bridge
    import dram_bridge_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_en,
    input  logic                cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wmask,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wen,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    output logic                err,
    output state_t              state_dbg
);

    // Handshake: a request transfers on a cycle with mem_req_valid && mem_req_ready;
    // valid and the request fields stay fixed until then. The response is a single
    // mem_rsp_valid strobe, honoured only at or after acceptance of the request.

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    state_t              state_q, state_d;
    req_t                req_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                cnt_clear, cnt_en, cnt_hit;
    logic                rsp_take;

    sat_counter #(.W(CNT_W)) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .en    (cnt_en),
        .limit (LIMIT),
        .hit   (cnt_hit)
    );

    assign rsp_take = ((state_q == REQ) && mem_req_ready && mem_rsp_valid) ||
                      ((state_q == WAIT) && mem_rsp_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && cpu_en) begin
                req_q <= '{wen: cpu_wen, addr: cpu_addr, wdata: cpu_wdata, wmask: cpu_wmask};
            end
            if (rsp_take) begin
                rdata_q <= mem_rsp_rdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cpu_stall     = 1'b0;
        mem_req_valid = 1'b0;
        cnt_clear     = 1'b0;
        cnt_en        = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_stall = cpu_en;
                if (cpu_en) begin
                    cnt_clear = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                cpu_stall     = 1'b1;
                mem_req_valid = 1'b1;
                cnt_en        = 1'b1;
                if (mem_req_ready && mem_rsp_valid) begin
                    state_d = DONE;
                end else if (cnt_hit) begin
                    state_d = ERR;
                end else if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cpu_stall = 1'b1;
                cnt_en    = 1'b1;
                if (mem_rsp_valid) begin
                    state_d = DONE;
                end else if (cnt_hit) begin
                    state_d = ERR;
                end
            end
            // cpu_en is deliberately ignored here so the committing instruction is not reissued.
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                cpu_stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req_wen   = req_q.wen;
    assign mem_req_addr  = req_q.addr;
    assign mem_req_wdata = req_q.wdata;
    assign mem_req_wmask = req_q.wmask;
    assign cpu_rdata     = rdata_q;
    assign err           = (state_q == ERR);
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_dram_bridge.sv
// Randomized bench for dram_bridge: per-access latency and data predicted
// from delays chosen by the bench, plus directed reset/timeout scenarios.
module tb_dram_bridge;
    import dram_bridge_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst, rst_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        cpu_en, cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_stall, mem_req_valid, mem_req_ready, mem_req_wen;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid, err;
    state_t      state_dbg;

    logic        cpu_en_t, ready_t, rsp_valid_t;
    logic [31:0] rdata_t, req_addr_t, req_wdata_t;
    logic [3:0]  req_wmask_t;
    logic        stall_t, req_valid_t, req_wen_t, err_t;
    state_t      state_t_dbg;

    dram_bridge dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_req_wmask(mem_req_wmask), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .err(err), .state_dbg(state_dbg)
    );

    dram_bridge #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst_t), .cpu_en(cpu_en_t), .cpu_wen(1'b0), .cpu_addr(32'h0000_0040),
        .cpu_wdata(32'h0), .cpu_wmask(4'h0), .cpu_rdata(rdata_t),
        .cpu_stall(stall_t), .mem_req_valid(req_valid_t), .mem_req_ready(ready_t),
        .mem_req_wen(req_wen_t), .mem_req_addr(req_addr_t), .mem_req_wdata(req_wdata_t),
        .mem_req_wmask(req_wmask_t), .mem_rsp_valid(rsp_valid_t),
        .mem_rsp_rdata(32'hDEAD_BEEF), .err(err_t), .state_dbg(state_t_dbg)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int n_access = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Access timeline: cycle 0 IDLE, then d_r cycles of REQ without ready, one accepting
    // REQ cycle, d_s WAIT cycles, then DONE. The core is released only in DONE.
    task automatic run_access(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wmask, input int d_r, input int d_s,
                              input logic [31:0] rdata, input logic strays);
        int total;
        total = 3 + d_r + d_s;
        if (!wen) exp_q.push_back(rdata);
        n_access++;
        for (int c = 0; c < total; c++) begin
            @(negedge clk);
            cpu_en = 1'b1;
            if (c == 0) begin
                cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_wmask = wmask;
            end else begin
                cpu_wen = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom;
                cpu_wmask = 4'($urandom_range(0, 15));
            end
            mem_req_ready = (c == 1 + d_r);
            mem_rsp_valid = (c == 1 + d_r + d_s);
            mem_rsp_rdata = mem_rsp_valid ? rdata : $urandom;
            if (strays && ((c == 0) || (c >= 1 && c <= d_r) || (c == total - 1)))
                mem_rsp_valid = 1'($urandom_range(0, 1));
            #1;
            check_eq("cpu_stall", 64'(cpu_stall), 64'(c != total - 1));
            check_eq("mem_req_valid", 64'(mem_req_valid), 64'((c >= 1) && (c <= 1 + d_r)));
            if ((c >= 1) && (c <= 1 + d_r)) begin
                check_eq("req_wen", 64'(mem_req_wen), 64'(wen));
                check_eq("req_addr", 64'(mem_req_addr), 64'(addr));
                check_eq("req_wdata", 64'(mem_req_wdata), 64'(wdata));
                check_eq("req_wmask", 64'(mem_req_wmask), 64'(wmask));
            end
            if (mem_req_valid && mem_req_ready) n_hs++;
            if ((c == total - 1) && !wen)
                check_eq("cpu_rdata", 64'(cpu_rdata), 64'(exp_q.pop_front()));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; rst_t = 1'b0;
        cpu_en = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wmask = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        cpu_en_t = 1'b0; ready_t = 1'b0; rsp_valid_t = 1'b0;

        // reset defaults
        #2;
        check_eq("rst_state", 64'(state_dbg), 64'(IDLE));
        check_eq("rst_valid", 64'(mem_req_valid), 64'(0));
        check_eq("rst_err", 64'(err), 64'(0));
        check_eq("rst_stall", 64'(cpu_stall), 64'(0));
        check_eq("rst_rdata", 64'(cpu_rdata), 64'(0));
        check_eq("rst_fields", 64'({mem_req_wen, mem_req_wmask}), 64'(0));
        check_eq("rst_addr", 64'(mem_req_addr), 64'(0));
        check_eq("rst_wdata", 64'(mem_req_wdata), 64'(0));
        @(negedge clk); rst = 1'b1; rst_t = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check_eq("idle_state", 64'(state_dbg), 64'(IDLE));
            check_eq("idle_stall", 64'(cpu_stall), 64'(0));
        end

        // zero-wait load, backpressured store, back-to-back load/store with strays
        run_access(1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 0, 32'h1234_5678, 1'b0);
        run_access(1'b1, 32'h8000_0020, 32'hA5A5_A5A5, 4'h3, 3, 2, 32'h0BAD_0BAD, 1'b0);
        run_access(1'b0, 32'h8000_0100, 32'h0, 4'hF, 1, 1, 32'hCAFE_F00D, 1'b1);
        run_access(1'b1, 32'h8000_0104, 32'h5555_AAAA, 4'hC, 0, 2, 32'h0, 1'b1);

        // randomized accesses
        for (int i = 0; i < 40; i++)
            run_access(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), $urandom, 1'b1);
        check_eq("handshakes", 64'(n_hs), 64'(n_access));

        // reset in the middle of an access
        @(negedge clk);
        cpu_en = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h8000_0200; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        @(negedge clk); mem_req_ready = 1'b1;
        @(negedge clk); mem_req_ready = 1'b0; #1;
        check_eq("mid_wait", 64'(state_dbg), 64'(WAIT));
        #1 rst = 1'b0; cpu_en = 1'b0; #1;
        check_eq("mid_rst_state", 64'(state_dbg), 64'(IDLE));
        check_eq("mid_rst_valid", 64'(mem_req_valid), 64'(0));
        check_eq("mid_rst_stall", 64'(cpu_stall), 64'(0));
        check_eq("mid_rst_rdata", 64'(cpu_rdata), 64'(0));
        @(negedge clk); rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h7777_1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_rsp_valid = 1'b0; #1;
            check_eq("late_rsp_state", 64'(state_dbg), 64'(IDLE));
            check_eq("late_rsp_rdata", 64'(cpu_rdata), 64'(0));
        end

        // timeout with TIMEOUT = 4 and ready never asserted
        for (int c = 0; c < 9; c++) begin
            @(negedge clk); cpu_en_t = (c == 0); #1;
            check_eq("to_valid", 64'(req_valid_t), 64'((c >= 1) && (c <= 4)));
            check_eq("to_err", 64'(err_t), 64'(c >= 5));
            check_eq("to_stall", 64'(stall_t), 64'(c <= 8));
        end
        @(negedge clk); rst_t = 1'b0; #1;
        check_eq("to_rst_err", 64'(err_t), 64'(0));
        check_eq("to_rst_state", 64'(state_t_dbg), 64'(IDLE));
        @(negedge clk); rst_t = 1'b1;
        @(negedge clk); #1;
        check_eq("to_after_err", 64'(err_t), 64'(0));
        check_eq("to_after_stall", 64'(stall_t), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dram_bridge.md
# dram_bridge

Data-memory bridge between the single-cycle core's combinational data-RAM port and a handshaked memory bus. It captures each core load or store, issues it on a valid/ready request channel, and waits for a response. While the access is outstanding it stalls the core, then presents the load data for exactly one commit cycle. It sits directly downstream of the core's data-memory port, in place of the zero-latency data RAM.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; the strobe is DATA_W/8 bits
- TIMEOUT, 255, maximum cycles allowed in REQ+WAIT before error; range 1..65535

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_en  in  1  core data-RAM access request
- cpu_wen  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  access address
- cpu_wdata  in  DATA_W  store data
- cpu_wmask  in  DATA_W/8  byte strobes
- cpu_rdata  out  DATA_W  load data; valid in DONE
- cpu_stall  out  1  core must hold PC and must not write the register file
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request accepted
- mem_req_wen  out  1  request direction
- mem_req_addr  out  ADDR_W  request address
- mem_req_wdata  out  DATA_W  request store data
- mem_req_wmask  out  DATA_W/8  request byte strobes
- mem_rsp_valid  in  1  response strobe; one per accepted request, loads and stores alike
- mem_rsp_rdata  in  DATA_W  response data
- err  out  1  timeout flag; sticky

## Operation
- FSM states are IDLE, REQ, WAIT, DONE and ERR.
- **IDLE**
  - cpu_stall = cpu_en, combinational.
  - If cpu_en = 1: register addr, wen, wdata and wmask, clear the timeout counter, go to REQ.
- **REQ**
  - mem_req_valid = 1; request fields driven from registers and stable until the handshake.
  - On mem_req_ready with mem_rsp_valid in the same cycle: capture rdata, go to DONE.
  - On mem_req_ready alone: go to WAIT.
- **WAIT**
  - mem_req_valid = 0.
  - On mem_rsp_valid: capture mem_rsp_rdata, go to DONE.
- **DONE**
  - cpu_stall = 0; cpu_rdata = captured data. The core commits on this edge.
  - Next state is always IDLE. cpu_en is ignored in DONE, so the same instruction is never reissued.
- **ERR**
  - Entered when the counter reaches TIMEOUT in REQ or WAIT.
  - cpu_stall = 1, mem_req_valid = 0 and err = 1 until reset.
- **Stores**
  - Wait for mem_rsp_valid exactly like loads.
  - cpu_rdata is captured but is don't-care for stores.
- **Responses outside WAIT**
  - mem_rsp_valid in IDLE or DONE is ignored.
  - mem_rsp_valid in REQ without mem_req_ready is ignored.
- **Timeout counter**
  - ceil(log2(TIMEOUT+1)) bits wide.
  - Increments in REQ and WAIT; saturates at TIMEOUT.
- **cpu_rdata**
  - Holds its last captured value outside DONE; it is a register, not a pass-through.

## Timing
- Reset values:
  - state IDLE, mem_req_valid 0, err 0.
  - mem_req_wen, mem_req_addr, mem_req_wdata and mem_req_wmask all 0.
  - cpu_rdata 0; cpu_stall 0 (its combinational value while cpu_en = 0).
- Reset assertion is asynchronous. It forces IDLE and drops mem_req_valid immediately, even in the middle of an access. A response arriving after reset is ignored.
- Best-case latency, with cpu_en seen at cycle 0 (IDLE):
  - cycle 1: REQ, with ready and response both high.
  - cycle 2: DONE.
  - The instruction therefore occupies 3 cycles.
- Each cycle ready stays low adds one cycle. Each cycle of response delay after acceptance adds one cycle.
- Back-to-back accesses: DONE→IDLE costs one cycle, so the next instruction's access is sampled in the following IDLE.
- Timeout is reached after TIMEOUT cycles spent in REQ+WAIT. The transition to ERR happens on that edge, and err rises the cycle after.

## Structure
- Shared package holds:
  - the state enum (IDLE, REQ, WAIT, DONE, ERR);
  - the request-record typedef (wen, addr, wdata, wmask).
- The timeout counter is a natural sub-module: `sat_counter` (clear, enable, limit, hit).
- The FSM, the request register and the response register stay in dram_bridge.

## Test plan
- **Reset defaults:** hold rst = 0 → all outputs at the reset values above. Release rst with cpu_en = 0 → stays in IDLE, cpu_stall = 0.
- **Zero-wait load:** load at addr 0x8000_0010; ready = 1 and rsp_valid = 1 with rdata 0x1234_5678 in cycle 1 → cpu_stall = 1,1,0 over cycles 0–2; cpu_rdata = 0x1234_5678 in cycle 2; mem_req_valid high only in cycle 1.
- **Backpressured store:** store to 0x8000_0020, wdata 0xA5A5_A5A5, wmask 0x3; ready low for 3 cycles, response 2 cycles after acceptance → request fields stable throughout REQ; cpu_stall deasserts exactly once, in cycle 7; no second request issued.
- **Back-to-back accesses:** a load then a store in consecutive instructions → exactly two request handshakes, separated by DONE and IDLE cycles; the stray rsp_valid injected in IDLE is ignored.
- **Timeout:** TIMEOUT = 4, ready never asserted → ERR entered after 4 REQ cycles; err = 1 and cpu_stall = 1 persist; an rst pulse returns to IDLE with err = 0.
- **Reset mid-access:** assert rst while in WAIT → mem_req_valid = 0 and state IDLE asynchronously. A response arriving after release does not produce a DONE cycle.
